// File: rtl/dma_dev_agent.sv
// dma_dev_agent: device-side initiator for a DMA controller device port.
// Issues one request per command, then streams words between a local buffer and the DMA.
`default_nettype none

module dma_dev_agent #(
    parameter int          ADD_LEN  = 16,
    parameter int          DATA_LEN = 16,
    parameter int          BUF_AW   = 5,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                cmd_start_i,
    input  logic                cmd_rd_wr_i,
    input  logic [ADD_LEN-1:0]  cmd_words_i,
    input  logic [ADD_LEN:0]    cmd_addr_i,
    input  logic                dev_hold_i,
    input  logic                host_we_i,
    input  logic [BUF_AW-1:0]   host_addr_i,
    input  logic [DATA_LEN-1:0] host_wdata_i,
    output logic [DATA_LEN-1:0] host_rdata_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [ADD_LEN-1:0]  xfer_cnt_o,
    output logic                rqst_o,
    output logic                rd_wr_o,
    output logic [ADD_LEN-1:0]  num_words_o,
    output logic [ADD_LEN:0]    start_addr_o,
    output logic                dev_ack_o,
    output logic [DATA_LEN-1:0] dev_in_o,
    input  logic                dma_ack_i,
    input  logic [DATA_LEN-1:0] dev_out_i,
    input  logic                end_flag_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

    localparam logic [ADD_LEN:0] DEPTH = {{ADD_LEN{1'b0}}, 1'b1} << BUF_AW;

    state_t              state_q, state_d;
    logic                rd_wr_q, rd_wr_d;
    logic [ADD_LEN-1:0]  num_q, num_d;
    logic [ADD_LEN:0]    addr_q, addr_d;
    logic [ADD_LEN-1:0]  cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [31:0]         wdog_q, wdog_d;
    logic                rej_q, rej_d;

    logic [DATA_LEN-1:0] mem [2**BUF_AW];
    logic                buf_we;
    logic [BUF_AW-1:0]   buf_wa;
    logic [DATA_LEN-1:0] buf_wd;
    logic                cnt_lt;

    assign cnt_lt = (cnt_q < num_q);

    always_comb begin
        state_d = state_q;
        rd_wr_d = rd_wr_q;
        num_d   = num_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
        rej_d   = 1'b0;
        buf_we  = 1'b0;
        buf_wa  = host_addr_i;
        buf_wd  = host_wdata_i;
        case (state_q)
            S_IDLE: begin
                wdog_d = '0;
                buf_we = host_we_i;
                if (cmd_start_i) begin
                    if ({1'b0, cmd_words_i} > DEPTH) begin
                        err_d = 1'b1;
                        rej_d = 1'b1;
                    end else begin
                        rd_wr_d = cmd_rd_wr_i;
                        num_d   = cmd_words_i;
                        addr_d  = cmd_addr_i;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                wdog_d  = wdog_q + 32'd1;
                state_d = S_XFER;
            end
            S_XFER: begin
                wdog_d = wdog_q + 32'd1;
                if (dma_ack_i) begin
                    if (cnt_lt) begin
                        cnt_d = cnt_q + 1'b1;
                        if (rd_wr_q) begin
                            buf_we = 1'b1;
                            buf_wa = cnt_q[BUF_AW-1:0];
                            buf_wd = dev_out_i;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // end_flag takes priority; the watchdog only fires without it
                if (end_flag_i) begin
                    state_d = S_DONE;
                end else if ((TIMEOUT != 0) && (wdog_q >= TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (cnt_q != num_q) err_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            rd_wr_q <= 1'b0;
            num_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_wr_q <= rd_wr_d;
            num_q   <= num_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
            rej_q   <= rej_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (buf_we) mem[buf_wa] <= buf_wd;
    end

    assign host_rdata_o = mem[host_addr_i];
    assign dev_in_o     = mem[cnt_q[BUF_AW-1:0]];
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE) | rej_q;
    assign err_o        = err_q;
    assign xfer_cnt_o   = cnt_q;
    assign rqst_o       = (state_q == S_REQ);
    assign rd_wr_o      = rd_wr_q;
    assign num_words_o  = num_q;
    assign start_addr_o = addr_q;
    assign dev_ack_o    = (state_q == S_XFER) & ~dev_hold_i & cnt_lt;

endmodule

`default_nettype wire
